deser_flex: RTL and testbench
=============================

DESER_FLEX -- requirements
Module: deser_flex

Interface
REQ-001 Parameter DATA_W, default 16, output word width in bits; SHALL be legal for 2..64.
REQ-002 Parameter MSB_FIRST, default 1, bit order: 1 = first received bit is word bit DATA_W-1; 0 = first received bit is word bit 0.
REQ-003 Parameter LEN_W, default $clog2(DATA_W+1), width of the length field; derived, not overridden.
REQ-004 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 srst_i  input  1  reset, synchronous and active-high.
REQ-006 data_i  input  1  serial data bit.
REQ-007 data_val_i  input  1  data_i is valid this cycle.
REQ-008 data_last_i  input  1  qualified by data_val_i; the current bit is the final bit of a word, including a partial word.
REQ-009 data_ready_o  output  1  block accepts a serial bit this cycle; a bit transfers when data_val_i && data_ready_o.
REQ-010 deser_data_o  output  DATA_W  assembled word.
REQ-011 deser_len_o  output  LEN_W  number of valid bits in deser_data_o, range 1..DATA_W.
REQ-012 deser_data_val_o  output  1  output word valid.
REQ-013 deser_ready_i  input  1  downstream accepts the word; a word transfers when deser_data_val_o && deser_ready_i.

Function
REQ-014 The block SHALL hold an assembly register (DATA_W bits), a bit counter (0..DATA_W-1), and a registered output stage: data, len, valid.
REQ-015 data_ready_o SHALL equal !deser_data_val_o || deser_ready_i, combinationally.
REQ-016 An accepted bit with counter value n SHALL be placed at bit DATA_W-1-n when MSB_FIRST=1, or at bit n when MSB_FIRST=0.
REQ-017 A word completes on an accepted bit when the counter is DATA_W-1, or when data_last_i=1.
REQ-018 On the completing edge the output stage SHALL load the assembled word including the completing bit, deser_len_o = n+1, and deser_data_val_o = 1; the output SHALL be visible in the cycle after the completing bit (latency 1).
REQ-019 On the completing edge the counter and assembly register SHALL clear to 0, so the next accepted bit starts a new word with no idle cycle.
REQ-020 Bit positions that did not receive a bit in a partial word SHALL read 0: the low bits when MSB_FIRST=1, the high bits when MSB_FIRST=0.
REQ-021 data_last_i on the DATA_W-th bit SHALL produce a single word with len = DATA_W; it SHALL NOT produce an extra empty word.
REQ-022 data_last_i SHALL be ignored when data_val_i=0 or data_ready_o=0.
REQ-023 A non-completing accepted bit SHALL increment the counter and leave the output stage unchanged.
REQ-024 While deser_data_val_o=1 and deser_ready_i=0, deser_data_o and deser_len_o SHALL hold stable, and no serial bit SHALL be accepted.
REQ-025 deser_data_val_o SHALL clear after a transfer unless a new word completes on the same edge; in that case it SHALL remain 1 and carry the new word (full throughput).
REQ-026 Cycles with data_val_i=0 SHALL not alter the counter or the assembly register; gaps within a word are allowed.
REQ-027 The block SHALL never drop or duplicate an accepted bit or an unaccepted word.

Reset
REQ-028 While srst_i=1 the following SHALL be 0: counter, assembly register, deser_data_o, deser_len_o, deser_data_val_o.
REQ-029 While srst_i=1, data_ready_o SHALL read 1, consistent with REQ-015; bits presented during reset are discarded.
REQ-030 Reset asserted mid-word or with a pending output word SHALL discard the partial and pending data; the first accepted bit after reset is bit 0 of a new word.

Verification
REQ-031 DATA_W=16, MSB_FIRST=1, ready=1; 16 consecutive bits of 0xA5C3, MSB first -> one cycle after the 16th bit: val=1, data=0xA5C3, len=16, for exactly one cycle.
REQ-032 Bits 1,0,1,1,0 with last on the 5th bit -> data=0xB000, len=5; a following full word 0x1234 -> data=0x1234, len=16.
REQ-033 Word 0xFFFF pending with deser_ready_i=0 for 10 cycles while data_val_i=1 -> data_ready_o=0, output stable, counter unchanged; raise ready -> 0xFFFF transfers; subsequent bits build the next word correctly.
REQ-034 32 continuous bits (0x0001 then 0x8000), ready=1 -> two words exactly 16 cycles apart, values and order correct.
REQ-035 7 bits, then srst_i for 1 cycle, then 16 bits of 0x1234 -> single word 0x1234, len=16, with no residue from the first 7 bits.
REQ-036 DATA_W=8, MSB_FIRST=0; bits 1,1,0,0,0,0,0,0 -> data=0x03, len=8; then 1,0,1 with last -> data=0x05, len=3.

Source files
------------

// File: rtl/deser_flex.sv
// Serial-to-parallel deserializer with configurable bit order, early word
// termination via data_last_i, and a single registered output stage.
module deser_flex #(
   parameter int unsigned DATA_W    = 16,
   parameter bit          MSB_FIRST = 1'b1,
   localparam int unsigned LEN_W    = $clog2(DATA_W + 1)
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              data_i,
   input  logic              data_val_i,
   input  logic              data_last_i,
   output logic              data_ready_o,
   output logic [DATA_W-1:0] deser_data_o,
   output logic [LEN_W-1:0]  deser_len_o,
   output logic              deser_data_val_o,
   input  logic              deser_ready_i
);

   localparam int unsigned CNT_W = $clog2(DATA_W);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] asm_q, asm_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [LEN_W-1:0]  out_len_q, out_len_d;
   logic              out_val_q, out_val_d;

   logic              accept;
   logic              complete;
   logic [CNT_W-1:0]  pos;
   logic [DATA_W-1:0] word;

   // A free output slot (or one being drained this cycle) lets a bit in.
   assign data_ready_o = srst_i || !out_val_q || deser_ready_i;

   always_comb begin
      cnt_d      = cnt_q;
      asm_d      = asm_q;
      out_data_d = out_data_q;
      out_len_d  = out_len_q;
      out_val_d  = out_val_q;

      accept   = data_val_i && data_ready_o;
      complete = accept && (data_last_i || (cnt_q == CNT_W'(DATA_W - 1)));
      pos      = MSB_FIRST ? (CNT_W'(DATA_W - 1) - cnt_q) : cnt_q;

      word      = asm_q;
      word[pos] = data_i;

      if (out_val_q && deser_ready_i) begin
         out_val_d = 1'b0;
      end

      if (complete) begin
         out_data_d = word;
         out_len_d  = LEN_W'(cnt_q) + LEN_W'(1);
         out_val_d  = 1'b1;
         cnt_d      = '0;
         asm_d      = '0;
      end else if (accept) begin
         cnt_d = cnt_q + CNT_W'(1);
         asm_d = word;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         cnt_q      <= '0;
         asm_q      <= '0;
         out_data_q <= '0;
         out_len_q  <= '0;
         out_val_q  <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         asm_q      <= asm_d;
         out_data_q <= out_data_d;
         out_len_q  <= out_len_d;
         out_val_q  <= out_val_d;
      end
   end

   assign deser_data_o     = out_data_q;
   assign deser_len_o      = out_len_q;
   assign deser_data_val_o = out_val_q;

endmodule

// File: tb/tb_deser_flex.sv
// Directed bench for deser_flex: a 16-bit MSB-first and an 8-bit LSB-first
// instance, each checked against a queue of expected words.
module tb_deser_flex;

   logic clk = 1'b0;
   logic srst;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // 16-bit, MSB first
   logic        a_din, a_val, a_last, a_rdy, a_oval, a_dready;
   logic [15:0] a_odata;
   logic [4:0]  a_olen;
   // 8-bit, LSB first
   logic        b_din, b_val, b_last, b_rdy, b_oval, b_dready;
   logic [7:0]  b_odata;
   logic [3:0]  b_olen;

   deser_flex #(.DATA_W(16), .MSB_FIRST(1'b1)) u_a (
      .clk_i(clk), .srst_i(srst), .data_i(a_din), .data_val_i(a_val),
      .data_last_i(a_last), .data_ready_o(a_rdy), .deser_data_o(a_odata),
      .deser_len_o(a_olen), .deser_data_val_o(a_oval), .deser_ready_i(a_dready)
   );

   deser_flex #(.DATA_W(8), .MSB_FIRST(1'b0)) u_b (
      .clk_i(clk), .srst_i(srst), .data_i(b_din), .data_val_i(b_val),
      .data_last_i(b_last), .data_ready_o(b_rdy), .deser_data_o(b_odata),
      .deser_len_o(b_olen), .deser_data_val_o(b_oval), .deser_ready_i(b_dready)
   );

   logic [20:0] qa[$];
   logic [11:0] qb[$];
   int          tq[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Word transfers are sampled at the falling edge preceding the transfer edge.
   always @(negedge clk) begin
      logic [20:0] ea;
      if (a_oval === 1'b1 && a_dready === 1'b1) begin
         ea = (qa.size() > 0) ? qa.pop_front() : 21'h1FFFFF;
         chk("a_word", 64'({a_olen, a_odata}), 64'(ea));
         tq.push_back(cyc);
      end
   end

   always @(negedge clk) begin
      logic [11:0] eb;
      if (b_oval === 1'b1 && b_dready === 1'b1) begin
         eb = (qb.size() > 0) ? qb.pop_front() : 12'hFFF;
         chk("b_word", 64'({b_olen, b_odata}), 64'(eb));
      end
   end

   task automatic send_bit_a(input logic b, input logic last);
      int k = 0;
      a_din = b; a_val = 1'b1; a_last = last;
      @(negedge clk);
      while (a_rdy !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k == 100) chk("a_ready_timeout", 64'(a_rdy), 64'(1));
      @(posedge clk); #1;
   endtask

   task automatic send_a(input logic [15:0] w, input int len, input bit last, input bit push);
      if (push) qa.push_back({5'(len), w & ~(16'hFFFF >> len)});
      for (int i = 0; i < len; i++) send_bit_a(w[15-i], last && (i == len - 1));
   endtask

   task automatic send_b(input logic [7:0] w, input int len, input bit last, input bit push);
      int k;
      if (push) qb.push_back({4'(len), w & (8'hFF >> (8 - len))});
      for (int i = 0; i < len; i++) begin
         k = 0;
         b_din = w[i]; b_val = 1'b1; b_last = last && (i == len - 1);
         @(negedge clk);
         while (b_rdy !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
         end
         if (k == 100) chk("b_ready_timeout", 64'(b_rdy), 64'(1));
         @(posedge clk); #1;
      end
   endtask

   task automatic idle();
      a_val = 1'b0; a_last = 1'b0; b_val = 1'b0; b_last = 1'b0;
   endtask

   initial begin
      logic [15:0] w;
      int k;
      srst = 1'b1;
      a_din = 1'b1; a_val = 1'b1; a_last = 1'b1; a_dready = 1'b1;
      b_din = 1'b1; b_val = 1'b1; b_last = 1'b1; b_dready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_a_val",   64'(a_oval),  64'(0));
      chk("rst_a_data",  64'(a_odata), 64'(0));
      chk("rst_a_len",   64'(a_olen),  64'(0));
      chk("rst_a_ready", 64'(a_rdy),   64'(1));
      chk("rst_b_val",   64'(b_oval),  64'(0));
      chk("rst_b_data",  64'(b_odata), 64'(0));
      @(posedge clk); #1;
      srst = 1'b0;
      idle();
      @(posedge clk); #1;

      // Full word, valid for exactly one cycle
      send_a(16'hA5C3, 16, 1'b0, 1'b1);
      idle();
      @(negedge clk);
      chk("a5c3_val",  64'(a_oval),  64'(1));
      chk("a5c3_data", 64'(a_odata), 64'hA5C3);
      chk("a5c3_len",  64'(a_olen),  64'(16));
      @(negedge clk);
      chk("a5c3_val_drop", 64'(a_oval), 64'(0));
      @(posedge clk); #1;

      // Partial word then full word, back to back; last on the 16th bit
      send_a(16'hB000, 5, 1'b1, 1'b1);
      send_a(16'h1234, 16, 1'b0, 1'b1);
      send_a(16'hC0DE, 16, 1'b1, 1'b1);
      idle();
      repeat (3) @(posedge clk); #1;

      // Gap inside a word, with last asserted but not qualified by valid
      w = 16'h9C3A;
      qa.push_back({5'd16, w});
      for (int i = 0; i < 8; i++) send_bit_a(w[15-i], 1'b0);
      a_val = 1'b0; a_last = 1'b1;
      repeat (3) @(posedge clk); #1;
      for (int i = 8; i < 16; i++) send_bit_a(w[15-i], 1'b0);
      idle();
      repeat (2) @(posedge clk); #1;

      // Back-pressure: pending word must hold and block serial input
      a_dready = 1'b0;
      send_a(16'hFFFF, 16, 1'b0, 1'b1);
      a_din = 1'b0; a_val = 1'b1; a_last = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_ready", 64'(a_rdy),   64'(0));
         chk("stall_val",   64'(a_oval),  64'(1));
         chk("stall_data",  64'(a_odata), 64'hFFFF);
         chk("stall_len",   64'(a_olen),  64'(16));
      end
      @(posedge clk); #1;
      a_dready = 1'b1;
      send_a(16'h1234, 16, 1'b0, 1'b1);
      idle();
      repeat (3) @(posedge clk); #1;

      // Continuous stream: two words exactly 16 cycles apart
      tq.delete();
      send_a(16'h0001, 16, 1'b0, 1'b1);
      send_a(16'h8000, 16, 1'b0, 1'b1);
      idle();
      repeat (3) @(posedge clk); #1;
      chk("stream_count", 64'(tq.size()), 64'(2));
      chk("stream_gap", 64'((tq.size() == 2) ? (tq[1] - tq[0]) : -1), 64'(16));

      // Reset mid-word discards the partial word
      send_a(16'hFE00, 7, 1'b0, 1'b0);
      idle();
      srst = 1'b1;
      @(posedge clk); #1;
      srst = 1'b0;
      @(negedge clk);
      chk("midrst_val",  64'(a_oval),  64'(0));
      chk("midrst_data", 64'(a_odata), 64'(0));
      @(posedge clk); #1;
      send_a(16'h1234, 16, 1'b0, 1'b1);
      send_a(16'hFE00, 7, 1'b0, 1'b0);
      idle();
      srst = 1'b1;
      @(posedge clk); #1;
      srst = 1'b0;
      send_a(16'hA000, 3, 1'b1, 1'b1);
      idle();
      repeat (3) @(posedge clk); #1;

      // 8-bit LSB-first instance
      send_b(8'h03, 8, 1'b0, 1'b1);
      send_b(8'h05, 3, 1'b1, 1'b1);
      send_b(8'hB6, 8, 1'b1, 1'b1);
      idle();
      @(negedge clk);
      chk("b_last_val",  64'(b_oval),  64'(1));
      chk("b_last_data", 64'(b_odata), 64'hB6);
      chk("b_last_len",  64'(b_olen),  64'(8));
      @(posedge clk); #1;

      k = 0;
      while ((qa.size() != 0 || qb.size() != 0) && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      repeat (4) @(posedge clk); #1;
      chk("a_queue_drained", 64'(qa.size()), 64'(0));
      chk("b_queue_drained", 64'(qb.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
